// File: rtl/data_mem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Request and response each use their own valid/ready handshake.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory. It accepts one request at a time, waits
// WAIT_CYCLES cycles, performs the access, then holds the response until it is taken.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  access;
    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_wstrb;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;

    assign accept = (state == IDLE) && bus.req_valid;
    // Gating with reset stops a zero-wait store from landing while reset is held.
    assign access = !reset &&
                    ((accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (wait_cnt == 4'd1)));

    // A zero-wait access uses the live request; every other access uses the captured one.
    // NOTE: each signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        acc_write = cap_write;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_wstrb = cap_wstrb;
        if (state == IDLE) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wstrb = bus.req_wstrb;
        end
    end

    assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign acc_idx = acc_addr[ADDR_WIDTH+1:2];

    // NOTE: the storage array has no reset; only control and output registers are cleared.
    always_ff @(posedge clk) begin
        if (access && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write <= bus.req_write;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        cap_wstrb <= bus.req_wstrb;
                        wait_cnt  <= WAIT_INIT;
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state   <= IDLE;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (access) begin
                rdata_q <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
                err_q   <= acc_err;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued at request
// time and compared when the response handshake happens.
module tb_data_mem_responder;
    localparam int ADDR_WIDTH  = 8;
    localparam int WAIT_CYCLES = 2;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    resp_t sb_q[$];

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the response handshake.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_data, input logic exp_err, input int hold);
        int          n;
        logic [31:0] held;
        resp_t       exp_r;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        bus.req_valid = 1'b1;
        sb_q.push_back('{err: exp_err, data: exp_data});
        @(negedge clk);
        check({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
        // Scramble the request lines: the responder must use the captured copy.
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = ~wdata;
        bus.req_wstrb = ~strb;
        n = 1;
        while (!bus.resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
        held = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, " held data"}, bus.resp_rdata, held);
            check({tag, " held req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            exp_r = sb_q.pop_front();
            check({tag, " rdata"}, bus.resp_rdata, exp_r.data);
            check({tag, " err"}, 32'(bus.resp_err), 32'(exp_r.err));
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " req_ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_wstrb  = 4'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        check("reset resp_err", 32'(bus.resp_err), 32'd0);

        do_req("st10",    1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        do_req("ld10",    1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        do_req("st10b0",  1'b1, 32'h10, 32'h0000_0055, 4'h1, 32'h0, 1'b0, 0);
        do_req("ld10b0",  1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BE55, 1'b0, 0);

        do_req("st0",     1'b1, 32'h0,   32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
        do_req("ld_mis",  1'b0, 32'h12,  32'h0,         4'h0, 32'h0, 1'b1, 0);
        do_req("st_oor",  1'b1, 32'h400, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0);
        do_req("ld_hi",   1'b0, 32'h8000_0000, 32'h0,   4'h0, 32'h0, 1'b1, 0);
        do_req("ld0",     1'b0, 32'h0,   32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 0);

        do_req("ld_bp",   1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BE55, 1'b0, 5);
        do_req("st_nop",  1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0);
        do_req("st_part", 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hA, 32'h0, 1'b0, 0);
        do_req("ld_part", 1'b0, 32'h10, 32'h0,         4'h0, 32'hA5AD_A555, 1'b0, 0);

        // Reset during the wait states of a store must discard that store.
        do_req("st20",    1'b1, 32'h20, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 0);
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h2222_2222;
        bus.req_wstrb = 4'hF;
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("rst_wait accepted", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wait req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_wait resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_wait resp_rdata", bus.resp_rdata, 32'd0);
        do_req("ld20",    1'b0, 32'h20, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
